// File: rtl/sb_mem_resp.sv
// sb_mem_resp: system-bus memory responder for fetch and load/store ports.
// Optional misalignment checking is enabled by defining SB_MISALIGN_CHK_EN.
module sb_mem_resp #(
  parameter int          DEPTH       = 4096,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] NOP_INST    = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_o,
  input  logic        mem_re_i,
  input  logic        mem_we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  byte_mask_i,
  input  logic        un_sign_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        hold_o,
  output logic        err_o
);

  localparam int          AW  = $clog2(DEPTH);
  localparam logic [32:0] LIM = 33'(DEPTH) << 2;

  // WAIT occupies WAIT_CYCLES cycles, but never fewer than one
  localparam logic [3:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0] r_mem [DEPTH];

  logic [31:0] r_inst;
  logic [31:0] r_addr;
  logic [3:0]  r_mask;
  logic        r_unsign;
  logic [31:0] r_wdata;
  logic        r_is_rd;
  logic        r_mis;
  logic [3:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_valid;

  logic        w_req;
  logic        w_accept;
  logic        w_resp;
  logic        w_do_write;
  logic        w_do_read;
  logic        w_f_oor;
  logic        w_d_oor;
  logic        w_mis;
  logic [2:0]  w_in_lanes;
  logic [2:0]  w_lanes;
  logic [31:0] w_word;
  logic [31:0] w_shift;
  logic [31:0] w_ext;

  assign w_req = mem_re_i | mem_we_i;

  // Fetch port: independent of the data FSM
  assign w_f_oor = {1'b0, inst_addr_i} >= LIM;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst <= NOP_INST;
    end else if (w_f_oor) begin
      r_inst <= NOP_INST;
    end else begin
      r_inst <= r_mem[inst_addr_i[AW+1:2]];
    end
  end

  assign inst_o = r_inst;

  // Data FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Data FSM: next state
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_req) w_next = S_WAIT;
      S_WAIT: if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Data FSM: outputs
  always_comb begin
    w_accept   = 1'b0;
    w_resp     = 1'b0;
    hold_o     = 1'b0;
    w_do_write = 1'b0;
    w_do_read  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_accept = w_req & ~rst;
        hold_o   = w_req & ~rst;
      end
      S_WAIT: hold_o = ~rst;
      S_RESP: w_resp = ~rst;
      default: ;
    endcase
    w_do_write = w_resp & ~r_is_rd & ~w_d_oor & ~r_mis;
    w_do_read  = w_resp & r_is_rd;
  end

  assign w_in_lanes = 3'($countones(byte_mask_i));

`ifdef SB_MISALIGN_CHK_EN
  always_comb begin
    w_mis = 1'b0;
    unique case (1'b1)
      (w_in_lanes == 3'd1):
        w_mis = byte_mask_i != (4'b0001 << addr_i[1:0]);
      (w_in_lanes == 3'd2):
        w_mis = !((byte_mask_i == 4'b0011) ||
                  (byte_mask_i == 4'b1100));
      (w_in_lanes == 3'd4):
        w_mis = addr_i[1:0] != 2'b00;
      default: w_mis = 1'b0;
    endcase
  end
`else
  assign w_mis = 1'b0;
`endif

  // Request capture; read wins when both strobes are high
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_mask   <= '0;
      r_unsign <= 1'b0;
      r_wdata  <= '0;
      r_is_rd  <= 1'b0;
      r_mis    <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_addr   <= addr_i;
      r_mask   <= byte_mask_i;
      r_unsign <= un_sign_i;
      r_wdata  <= wdata_i;
      r_is_rd  <= mem_re_i;
      r_mis    <= w_mis;
      r_cnt    <= CNT_INIT;
    end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign w_d_oor = {1'b0, r_addr} >= LIM;
  assign w_word  = r_mem[r_addr[AW+1:2]];
  assign w_lanes = 3'($countones(r_mask));

  always_comb begin
    w_shift = w_word >> {r_addr[1:0], 3'b000};
    w_ext   = w_shift;
    unique case (1'b1)
      (w_lanes == 3'd0): w_ext = '0;
      (w_lanes == 3'd1):
        w_ext = r_unsign ? {24'b0, w_shift[7:0]}
                         : {{24{w_shift[7]}}, w_shift[7:0]};
      (w_lanes == 3'd2):
        w_ext = r_unsign ? {16'b0, w_shift[15:0]}
                         : {{16{w_shift[15]}}, w_shift[15:0]};
      default: w_ext = w_shift;
    endcase
    if (w_d_oor || r_mis) w_ext = '0;
  end

  always_ff @(posedge clk) begin
    if (w_do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (r_mask[b]) begin
          r_mem[r_addr[AW+1:2]][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_do_read;
      if (w_do_read) r_rdata <= w_ext;
    end
  end

  assign rdata_o       = r_rdata;
  assign rdata_valid_o = r_valid;

`ifdef SB_MISALIGN_CHK_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_resp & r_mis;
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sb_mem_resp.sv
// tb_sb_mem_resp: directed bench for sb_mem_resp (WAIT_CYCLES = 2).
// Honours SB_MISALIGN_CHK_EN when choosing misaligned-access expectations.
module tb_sb_mem_resp;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst_addr_i = '0;
  logic [31:0] inst_o;
  logic        mem_re_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [3:0]  byte_mask_i = '0;
  logic        un_sign_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        hold_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  int          hc;
  logic        v;
  logic        v2;
  logic        e;
  logic [31:0] rd;
  logic [31:0] io1;
  logic [31:0] io2;

  sb_mem_resp #(
    .DEPTH(4096),
    .WAIT_CYCLES(2),
    .NOP_INST(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .inst_addr_i(inst_addr_i),
    .inst_o(inst_o),
    .mem_re_i(mem_re_i),
    .mem_we_i(mem_we_i),
    .addr_i(addr_i),
    .byte_mask_i(byte_mask_i),
    .un_sign_i(un_sign_i),
    .wdata_i(wdata_i),
    .rdata_o(rdata_o),
    .rdata_valid_o(rdata_valid_o),
    .hold_o(hold_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus transaction; returns hold length, response and fetch samples
  task automatic xact(input logic re, input logic we,
                      input logic [31:0] a, input logic [3:0] m,
                      input logic u, input logic [31:0] wd,
                      output int n, output logic vo, output logic vn,
                      output logic eo, output logic [31:0] ro,
                      output logic [31:0] i1, output logic [31:0] i2);
    mem_re_i = re;
    mem_we_i = we;
    addr_i = a;
    byte_mask_i = m;
    un_sign_i = u;
    wdata_i = wd;
    #1;
    n = 0;
    eo = err_o;
    while (hold_o && n < 20) begin
      tick();
      n++;
      eo = eo | err_o;
    end
    mem_re_i = 1'b0;
    mem_we_i = 1'b0;
    tick();
    vo = rdata_valid_o;
    ro = rdata_o;
    i1 = inst_o;
    eo = eo | err_o;
    tick();
    vn = rdata_valid_o;
    i2 = inst_o;
    eo = eo | err_o;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_inst", inst_o, NOP);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_valid", 32'(rdata_valid_o), 32'h0);
    chk("rst_hold", 32'(hold_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    rst = 1'b0;
    tick();

    xact(1'b0, 1'b1, 32'h0, 4'hF, 1'b0, 32'h00500093,
         hc, v, v2, e, rd, io1, io2);
    rst = 1'b1;
    #1;
    tick();
    chk("fetch_in_rst", inst_o, NOP);
    rst = 1'b0;
    tick();
    chk("fetch_0", inst_o, 32'h00500093);
    inst_addr_i = 32'h40;

    xact(1'b0, 1'b1, 32'h10, 4'hF, 1'b0, 32'hDEADBEEF,
         hc, v, v2, e, rd, io1, io2);
    chk("st_hold_len", 32'(hc), 32'd3);
    chk("st_no_valid", 32'(v), 32'h0);
    chk("st_no_err", 32'(e), 32'h0);

    xact(1'b1, 1'b0, 32'h10, 4'hF, 1'b0, 32'h0,
         hc, v, v2, e, rd, io1, io2);
    chk("ld_hold_len", 32'(hc), 32'd3);
    chk("ld_valid", 32'(v), 32'h1);
    chk("ld_word", rd, 32'hDEADBEEF);
    chk("ld_valid_pulse", 32'(v2), 32'h0);
    chk("ld_rdata_hold", rdata_o, 32'hDEADBEEF);

    xact(1'b1, 1'b0, 32'h13, 4'b1000, 1'b0, 32'h0,
         hc, v, v2, e, rd, io1, io2);
    chk("lb_signed", rd, 32'hFFFFFFDE);
    xact(1'b1, 1'b0, 32'h13, 4'b1000, 1'b1, 32'h0,
         hc, v, v2, e, rd, io1, io2);
    chk("lbu", rd, 32'h000000DE);
    xact(1'b1, 1'b0, 32'h11, 4'b0010, 1'b0, 32'h0,
         hc, v, v2, e, rd, io1, io2);
    chk("lb_lane1", rd, 32'hFFFFFFBE);

    xact(1'b0, 1'b1, 32'h12, 4'b1100, 1'b0, 32'h12340000,
         hc, v, v2, e, rd, io1, io2);
    xact(1'b1, 1'b0, 32'h10, 4'hF, 1'b0, 32'h0,
         hc, v, v2, e, rd, io1, io2);
    chk("sh_word", rd, 32'h1234BEEF);
    xact(1'b1, 1'b0, 32'h12, 4'b1100, 1'b0, 32'h0,
         hc, v, v2, e, rd, io1, io2);
    chk("lh_hi", rd, 32'h00001234);
    xact(1'b1, 1'b0, 32'h10, 4'b0011, 1'b0, 32'h0,
         hc, v, v2, e, rd, io1, io2);
    chk("lh_lo_signed", rd, 32'hFFFFBEEF);
    xact(1'b1, 1'b0, 32'h10, 4'b0011, 1'b1, 32'h0,
         hc, v, v2, e, rd, io1, io2);
    chk("lhu_lo", rd, 32'h0000BEEF);

    xact(1'b1, 1'b1, 32'h10, 4'hF, 1'b0, 32'h0,
         hc, v, v2, e, rd, io1, io2);
    chk("both_valid", 32'(v), 32'h1);
    chk("both_rdata", rd, 32'h1234BEEF);
    xact(1'b1, 1'b0, 32'h10, 4'hF, 1'b0, 32'h0,
         hc, v, v2, e, rd, io1, io2);
    chk("both_ram", rd, 32'h1234BEEF);

    mem_we_i = 1'b1;
    addr_i = 32'h10;
    byte_mask_i = 4'hF;
    wdata_i = 32'hCAFEF00D;
    #1;
    chk("rw_hold_req", 32'(hold_o), 32'h1);
    tick();
    chk("rw_hold_wait", 32'(hold_o), 32'h1);
    rst = 1'b1;
    #1;
    chk("rw_hold_rst", 32'(hold_o), 32'h0);
    mem_we_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    xact(1'b1, 1'b0, 32'h10, 4'hF, 1'b0, 32'h0,
         hc, v, v2, e, rd, io1, io2);
    chk("rw_discard", rd, 32'h1234BEEF);

    xact(1'b1, 1'b0, 32'h4000, 4'hF, 1'b0, 32'h0,
         hc, v, v2, e, rd, io1, io2);
    chk("oor_rd_valid", 32'(v), 32'h1);
    chk("oor_rd_zero", rd, 32'h0);
    xact(1'b0, 1'b1, 32'h4010, 4'hF, 1'b0, 32'h0BADF00D,
         hc, v, v2, e, rd, io1, io2);
    xact(1'b1, 1'b0, 32'h10, 4'hF, 1'b0, 32'h0,
         hc, v, v2, e, rd, io1, io2);
    chk("oor_wr_drop", rd, 32'h1234BEEF);

    xact(1'b1, 1'b0, 32'h10, 4'h0, 1'b0, 32'h0,
         hc, v, v2, e, rd, io1, io2);
    chk("m0_rd_hold", 32'(hc), 32'd3);
    chk("m0_rd_valid", 32'(v), 32'h1);
    chk("m0_rd_zero", rd, 32'h0);
    xact(1'b0, 1'b1, 32'h10, 4'h0, 1'b0, 32'h0,
         hc, v, v2, e, rd, io1, io2);
    chk("m0_wr_hold", 32'(hc), 32'd3);
    xact(1'b1, 1'b0, 32'h10, 4'hF, 1'b0, 32'h0,
         hc, v, v2, e, rd, io1, io2);
    chk("m0_wr_none", rd, 32'h1234BEEF);

    inst_addr_i = 32'h10;
    tick();
    xact(1'b0, 1'b1, 32'h10, 4'hF, 1'b0, 32'hA5A5A5A5,
         hc, v, v2, e, rd, io1, io2);
    chk("rbw_old", io1, 32'h1234BEEF);
    chk("rbw_new", io2, 32'hA5A5A5A5);

    xact(1'b0, 1'b1, 32'h11, 4'hF, 1'b0, 32'h55667788,
         hc, v, v2, e, rd, io1, io2);
    xact(1'b1, 1'b0, 32'h10, 4'hF, 1'b0, 32'h0,
         hc, v, v2, e, rd, io1, io2);
`ifdef SB_MISALIGN_CHK_EN
    chk("mis_ram", rd, 32'hA5A5A5A5);
`else
    chk("mis_ram", rd, 32'h55667788);
`endif
    xact(1'b0, 1'b1, 32'h11, 4'hF, 1'b0, 32'h55667788,
         hc, v, v2, e, rd, io1, io2);
`ifdef SB_MISALIGN_CHK_EN
    chk("mis_err", 32'(e), 32'h1);
`else
    chk("mis_err", 32'(e), 32'h0);
`endif

    inst_addr_i = 32'h4000;
    tick();
    chk("fetch_oor", inst_o, NOP);
    inst_addr_i = 32'h0;
    tick();
    chk("fetch_back", inst_o, 32'h00500093);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
